// File: rtl/regfile_sb.sv
// Parametrised integer register file with a per-register pending scoreboard.
// Decode reads operands and busy flags combinationally, issue marks the
// destination as pending, writeback stores data and clears the pending bit,
// and flush drops every outstanding reservation at once.
module regfile_sb #(
  parameter int XLEN     = 32,
  parameter int AW       = 5,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic            rs1_busy,
  output logic            rs2_busy,
  output logic            hazard,
  input  logic            issue_valid,
  input  logic [AW-1:0]   issue_rd,
  input  logic            wb_valid,
  input  logic [AW-1:0]   wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic            flush,
  input  logic [AW-1:0]   dbg_addr,
  output logic [XLEN-1:0] dbg_data,
  output logic [AW:0]     busy_cnt
);

  localparam int NREG = 1 << AW;

  logic [XLEN-1:0] regs [NREG];
  logic [NREG-1:0] pending;
  logic [NREG-1:0] pending_nxt;
  logic [AW:0]     cnt_nxt;
  logic            armed;
  logic            wb_en;
  logic            issue_en;
  logic            hit1;
  logic            hit2;

  // Register 0 is hardwired to zero and never pending when ZERO_REG is set.
  function automatic logic hardwired(input logic [AW-1:0] addr);
    return ZERO_REG && (addr == '0);
  endfunction

  // armed stays low for the first edge after reset release, so a write or
  // issue coinciding with the deassertion edge is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) armed <= 1'b0;
    else        armed <= 1'b1;
  end

  assign wb_en    = armed & wb_valid & ~hardwired(wb_rd);
  assign issue_en = armed & issue_valid & ~hardwired(issue_rd);

  // Register array write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the array is cleared by reset because software may read a
      // register before ever writing it; this is why it maps to flops, not RAM.
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (wb_en) begin
      // NOTE: state is updated with <= so every flop samples pre-edge values.
      regs[wb_rd] <= wb_data;
    end
  end

  // Next pending vector: flush beats everything, else clear on wb then set on issue.
  always_comb begin
    // NOTE: default first so no path leaves pending_nxt unassigned (no latch).
    pending_nxt = pending;
    if (armed && flush) begin
      pending_nxt = '0;
    end else begin
      if (wb_en)    pending_nxt[wb_rd]    = 1'b0;
      if (issue_en) pending_nxt[issue_rd] = 1'b1;
    end
  end

  // Popcount of the next pending vector, registered alongside it.
  always_comb begin
    cnt_nxt = '0;
    for (int i = 0; i < NREG; i++) cnt_nxt = cnt_nxt + {{AW{1'b0}}, pending_nxt[i]};
  end

  // Scoreboard and its population count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending  <= '0;
      busy_cnt <= '0;
    end else begin
      pending  <= pending_nxt;
      busy_cnt <= cnt_nxt;
    end
  end

  assign hit1 = BYPASS && wb_valid && (wb_rd == rs1_addr);
  assign hit2 = BYPASS && wb_valid && (wb_rd == rs2_addr);

  // Read port 1: zero register, then writeback forwarding, then the array.
  always_comb begin
    rs1_data = '0;
    rs1_busy = 1'b0;
    if (rst_n && !hardwired(rs1_addr)) begin
      if (hit1) begin
        rs1_data = wb_data;
      end else begin
        rs1_data = regs[rs1_addr];
        rs1_busy = pending[rs1_addr];
      end
    end
  end

  // Read port 2: same priority as port 1.
  always_comb begin
    rs2_data = '0;
    rs2_busy = 1'b0;
    if (rst_n && !hardwired(rs2_addr)) begin
      if (hit2) begin
        rs2_data = wb_data;
      end else begin
        rs2_data = regs[rs2_addr];
        rs2_busy = pending[rs2_addr];
      end
    end
  end

  assign hazard = rs1_busy | rs2_busy;

  // Debug port looks at the array only, never at in-flight writeback data.
  always_comb begin
    dbg_data = '0;
    if (rst_n && !hardwired(dbg_addr)) dbg_data = regs[dbg_addr];
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb (default parameters): directed vector
// table for the scoreboard corner cases, randomised traffic against an
// array-based reference model, and an asynchronous reset in mid-operation.
module tb_regfile_sb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  rs1_addr, rs2_addr, dbg_addr, issue_rd, wb_rd;
  logic [31:0] rs1_data, rs2_data, dbg_data, wb_data;
  logic        rs1_busy, rs2_busy, hazard, issue_valid, wb_valid, flush;
  logic [5:0]  busy_cnt;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: architectural registers and the set of pending rds.
  logic [31:0] m_regs [32];
  logic [31:0] m_pend;
  bit          m_armed;

  typedef struct {
    logic        flush;
    logic        iv;
    logic [4:0]  ird;
    logic        wv;
    logic [4:0]  wrd;
    logic [31:0] wdata;
    logic [4:0]  a1, a2, ad;
    logic [31:0] e1;
    logic        eb1, eb2;
    logic [31:0] ed;
    logic [5:0]  ecnt;
  } vec_t;

  vec_t vecs[$];

  regfile_sb dut (
    .clk(clk), .rst_n(rst_n),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy), .hazard(hazard),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .flush(flush), .dbg_addr(dbg_addr), .dbg_data(dbg_data),
    .busy_cnt(busy_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (wb_valid && wb_rd == a) return wb_data;
    return m_regs[a];
  endfunction

  function automatic logic m_busy(input logic [4:0] a);
    if (a == 5'd0) return 1'b0;
    if (wb_valid && wb_rd == a) return 1'b0;
    return m_pend[a];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    m_pend  = 32'd0;
    m_armed = 1'b0;
  endtask

  // Apply the current inputs to the model, then advance past the next edge.
  task automatic tick();
    if (m_armed) begin
      if (wb_valid && wb_rd != 5'd0) m_regs[wb_rd] = wb_data;
      if (flush) m_pend = 32'd0;
      else begin
        if (wb_valid && wb_rd != 5'd0)       m_pend[wb_rd]    = 1'b0;
        if (issue_valid && issue_rd != 5'd0) m_pend[issue_rd] = 1'b1;
      end
    end
    m_armed = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    issue_valid = 1'b0; issue_rd = 5'd0;
    wb_valid = 1'b0; wb_rd = 5'd0; wb_data = 32'd0;
    flush = 1'b0;
  endtask

  task automatic read_all(input string tag);
    for (int a = 0; a < 32; a++) begin
      rs1_addr = 5'(a); rs2_addr = 5'(31 - a); dbg_addr = 5'(a);
      #1;
      check($sformatf("%s rs1_data[%0d]", tag, a), rs1_data, 32'd0);
      check($sformatf("%s rs2_data[%0d]", tag, 31 - a), rs2_data, 32'd0);
      check($sformatf("%s dbg_data[%0d]", tag, a), dbg_data, 32'd0);
      check($sformatf("%s busy[%0d]", tag, a), {30'd0, rs1_busy, rs2_busy}, 32'd0);
    end
    check({tag, " busy_cnt"}, 32'(busy_cnt), 32'd0);
  endtask

  initial begin
    // Directed sequence: expected values worked out by hand from the rules.
    //                 fl  iv  ird  wv  wrd wdata          a1  a2  ad  e1             eb1 eb2 ed             cnt
    vecs.push_back('{1'b0,1'b0,5'd0,1'b1,5'd5,32'hDEADBEEF,5'd5,5'd0,5'd5,32'hDEADBEEF,1'b0,1'b0,32'h0,       6'd0});
    vecs.push_back('{1'b0,1'b0,5'd0,1'b0,5'd0,32'h0,       5'd0,5'd0,5'd5,32'h0,       1'b0,1'b0,32'hDEADBEEF,6'd0});
    vecs.push_back('{1'b0,1'b1,5'd7,1'b0,5'd0,32'h0,       5'd7,5'd7,5'd7,32'h0,       1'b0,1'b0,32'h0,       6'd1});
    vecs.push_back('{1'b0,1'b0,5'd0,1'b0,5'd0,32'h0,       5'd5,5'd7,5'd0,32'hDEADBEEF,1'b0,1'b1,32'h0,       6'd1});
    vecs.push_back('{1'b0,1'b0,5'd0,1'b1,5'd7,32'h12,      5'd7,5'd7,5'd7,32'h12,      1'b0,1'b0,32'h0,       6'd0});
    vecs.push_back('{1'b0,1'b1,5'd3,1'b0,5'd0,32'h0,       5'd7,5'd3,5'd7,32'h12,      1'b0,1'b0,32'h12,      6'd1});
    vecs.push_back('{1'b0,1'b1,5'd3,1'b1,5'd3,32'h33,      5'd3,5'd3,5'd3,32'h33,      1'b0,1'b0,32'h0,       6'd1});
    vecs.push_back('{1'b0,1'b1,5'd3,1'b0,5'd0,32'h0,       5'd3,5'd0,5'd3,32'h33,      1'b1,1'b0,32'h33,      6'd1});
    vecs.push_back('{1'b0,1'b0,5'd0,1'b1,5'd3,32'h44,      5'd3,5'd3,5'd3,32'h44,      1'b0,1'b0,32'h33,      6'd0});
    vecs.push_back('{1'b0,1'b1,5'd1,1'b0,5'd0,32'h0,       5'd1,5'd3,5'd3,32'h0,       1'b0,1'b0,32'h44,      6'd1});
    vecs.push_back('{1'b0,1'b1,5'd2,1'b0,5'd0,32'h0,       5'd1,5'd2,5'd0,32'h0,       1'b1,1'b0,32'h0,       6'd2});
    vecs.push_back('{1'b0,1'b1,5'd4,1'b0,5'd0,32'h0,       5'd2,5'd4,5'd0,32'h0,       1'b1,1'b0,32'h0,       6'd3});
    vecs.push_back('{1'b1,1'b1,5'd9,1'b1,5'd2,32'h55,      5'd2,5'd4,5'd2,32'h55,      1'b0,1'b1,32'h0,       6'd0});
    vecs.push_back('{1'b0,1'b0,5'd0,1'b0,5'd0,32'h0,       5'd9,5'd1,5'd2,32'h0,       1'b0,1'b0,32'h55,      6'd0});
    vecs.push_back('{1'b0,1'b1,5'd0,1'b1,5'd0,32'hFFFFFFFF,5'd0,5'd0,5'd0,32'h0,       1'b0,1'b0,32'h0,       6'd0});
    vecs.push_back('{1'b0,1'b0,5'd0,1'b0,5'd0,32'h0,       5'd0,5'd0,5'd0,32'h0,       1'b0,1'b0,32'h0,       6'd0});

    // Reset asserted with a live bypass request: outputs must still be 0.
    model_reset();
    rst_n = 1'b0;
    idle();
    wb_valid = 1'b1; wb_rd = 5'd5; wb_data = 32'hA5A5A5A5;
    rs1_addr = 5'd5; rs2_addr = 5'd5; dbg_addr = 5'd5;
    #2;
    check("in-reset rs1_data", rs1_data, 32'd0);
    check("in-reset rs2_data", rs2_data, 32'd0);
    idle();
    #21;
    rst_n = 1'b1;
    tick();
    read_all("post-reset");

    // Directed table.
    foreach (vecs[i]) begin
      flush = vecs[i].flush;
      issue_valid = vecs[i].iv; issue_rd = vecs[i].ird;
      wb_valid = vecs[i].wv; wb_rd = vecs[i].wrd; wb_data = vecs[i].wdata;
      rs1_addr = vecs[i].a1; rs2_addr = vecs[i].a2; dbg_addr = vecs[i].ad;
      #1;
      check($sformatf("v%0d rs1_data", i), rs1_data, vecs[i].e1);
      check($sformatf("v%0d rs1_busy", i), 32'(rs1_busy), 32'(vecs[i].eb1));
      check($sformatf("v%0d rs2_busy", i), 32'(rs2_busy), 32'(vecs[i].eb2));
      check($sformatf("v%0d hazard", i), 32'(hazard), 32'(vecs[i].eb1 | vecs[i].eb2));
      check($sformatf("v%0d dbg_data", i), dbg_data, vecs[i].ed);
      tick();
      check($sformatf("v%0d busy_cnt", i), 32'(busy_cnt), 32'(vecs[i].ecnt));
    end
    idle();

    // Randomised traffic; narrow address range half the time to force collisions.
    for (int n = 0; n < 400; n++) begin
      bit narrow;
      narrow = ($urandom_range(0, 1) == 1);
      rs1_addr    = narrow ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
      rs2_addr    = narrow ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
      dbg_addr    = narrow ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
      issue_rd    = narrow ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
      wb_rd       = narrow ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
      issue_valid = ($urandom_range(0, 2) != 0);
      wb_valid    = ($urandom_range(0, 2) == 0);
      wb_data     = $urandom;
      flush       = ($urandom_range(0, 15) == 0);
      #1;
      check($sformatf("r%0d rs1_data", n), rs1_data, m_read(rs1_addr));
      check($sformatf("r%0d rs2_data", n), rs2_data, m_read(rs2_addr));
      check($sformatf("r%0d rs1_busy", n), 32'(rs1_busy), 32'(m_busy(rs1_addr)));
      check($sformatf("r%0d rs2_busy", n), 32'(rs2_busy), 32'(m_busy(rs2_addr)));
      check($sformatf("r%0d hazard", n), 32'(hazard), 32'(m_busy(rs1_addr) | m_busy(rs2_addr)));
      check($sformatf("r%0d dbg_data", n), dbg_data, (dbg_addr == 5'd0) ? 32'd0 : m_regs[dbg_addr]);
      tick();
      check($sformatf("r%0d busy_cnt", n), 32'(busy_cnt), 32'($countones(m_pend)));
    end

    // Reset in mid-operation with pending bits and an active writeback.
    idle();
    flush = 1'b1;
    tick();
    idle();
    issue_valid = 1'b1; issue_rd = 5'd10;
    tick();
    issue_rd = 5'd11;
    wb_valid = 1'b1; wb_rd = 5'd10; wb_data = 32'h0BAD_F00D;
    tick();
    issue_valid = 1'b0;
    wb_valid = 1'b1; wb_rd = 5'd12; wb_data = 32'hCAFE_0001;
    rs1_addr = 5'd12; rs2_addr = 5'd11; dbg_addr = 5'd10;
    #1;
    check("pre-rst busy_cnt", 32'(busy_cnt), 32'd1);
    check("pre-rst rs1_data bypass", rs1_data, 32'hCAFE_0001);
    check("pre-rst rs2_busy", 32'(rs2_busy), 32'd1);
    check("pre-rst dbg_data", dbg_data, 32'h0BAD_F00D);
    rst_n = 1'b0;
    model_reset();
    #1;
    check("mid-rst rs1_data", rs1_data, 32'd0);
    check("mid-rst rs2_busy", 32'(rs2_busy), 32'd0);
    check("mid-rst hazard", 32'(hazard), 32'd0);
    check("mid-rst dbg_data", dbg_data, 32'd0);
    check("mid-rst busy_cnt", 32'(busy_cnt), 32'd0);
    issue_valid = 1'b1; issue_rd = 5'd13;
    @(posedge clk);
    #1;
    check("held-rst rs1_data", rs1_data, 32'd0);
    check("held-rst busy_cnt", 32'(busy_cnt), 32'd0);
    idle();
    #3;
    rst_n = 1'b1;
    tick();
    read_all("re-reset");

    // Ordinary write still works after the second reset.
    wb_valid = 1'b1; wb_rd = 5'd10; wb_data = 32'h0000_1234;
    tick();
    idle();
    dbg_addr = 5'd10;
    #1;
    check("post-reset write dbg_data", dbg_data, m_regs[10]);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised successor to the core integer register file.
- Configurable data width and register count, with optional x0 hardwiring and optional same-cycle write-to-read bypass.
- Adds a per-register pending scoreboard (set at issue, cleared at writeback, cleared by flush) so decode can detect RAW hazards and stall.
- Sits between decode/issue (read ports, issue) and writeback (write port); also has a debug read port for the test bench and monitor.

Parameters:
XLEN, 32, data width of each register in bits
AW, 5, register address width; NREG = 2**AW registers
ZERO_REG, 1, 1: register 0 reads as 0, ignores writes and is never pending; 0: register 0 is an ordinary register
BYPASS, 1, 1: writeback data and writeback clear forwarded combinationally to read ports in the same cycle; 0: no forwarding

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
rs1_addr  input  AW  read port 1 address
rs2_addr  input  AW  read port 2 address
rs1_data  output  XLEN  read port 1 data (combinational)
rs2_data  output  XLEN  read port 2 data (combinational)
rs1_busy  output  1  register at rs1_addr has a pending write
rs2_busy  output  1  register at rs2_addr has a pending write
hazard  output  1  rs1_busy | rs2_busy
issue_valid  input  1  an instruction writing issue_rd is issued this cycle
issue_rd  input  AW  destination of issued instruction
wb_valid  input  1  writeback this cycle
wb_rd  input  AW  writeback destination
wb_data  input  XLEN  writeback data
flush  input  1  synchronous clear of all pending bits
dbg_addr  input  AW  debug read address
dbg_data  output  XLEN  debug read data (combinational, never bypassed)
busy_cnt  output  AW+1  registered count of pending bits

Behaviour:
Reset:
- rst_n low asynchronously clears all registers, all pending bits and busy_cnt to 0.
- All outputs read 0 while rst_n is low.
- Reset mid-operation discards all in-flight state. No write or issue takes effect on the edge where rst_n deasserts.

Write:
- On a rising edge, reg[wb_rd] <= wb_data when wb_valid is high.
- Suppressed when ZERO_REG=1 and wb_rd=0.
- Write latency: 1 cycle to the array, 0 cycles to the read ports when BYPASS=1.

Read (per port n):
- Address 0 with ZERO_REG=1: data = 0, busy = 0.
- Otherwise, with BYPASS=1, wb_valid=1 and wb_rd=rsn_addr: data = wb_data, busy = 0.
- Otherwise: data = reg[rsn_addr], busy = pending[rsn_addr].
- An issue in the same cycle does not affect busy until the next cycle.

Pending update on each edge, in priority order:
1. flush=1: all pending cleared. A concurrent issue is ignored. A concurrent wb still writes data.
2. Otherwise, wb_valid clears pending[wb_rd], then issue_valid sets pending[issue_rd].
   - Issue and wb to the same rd in one cycle: the bit ends set (the new producer wins).
   - Issue to an already-pending rd (WAW): the bit stays set and is counted once.
   - Wb to a non-pending rd: data is written, the bit stays 0, the count is unchanged.
   - Issue or wb to rd=0 with ZERO_REG=1: no effect on pending.

busy_cnt:
- Equals the popcount of the pending vector, registered with the pending update.
- Range 0..NREG; the AW+1 width means it never wraps.

dbg_data:
- Equals reg[dbg_addr]; 0 for address 0 when ZERO_REG=1.
- Shows no bypass; it reflects the array only.

Test Plan:
- Reset then read all 32 addresses on rs1, rs2 and dbg -> all data 0, busy 0, busy_cnt 0.
- wb_valid, wb_rd=5, wb_data=0xDEADBEEF with rs1_addr=5 in the same cycle, BYPASS=1 -> rs1_data=0xDEADBEEF immediately; dbg_data(5) shows 0 until the edge, then 0xDEADBEEF.
- Issue rd=7; next cycle rs2_addr=7 -> rs2_busy=1, hazard=1, busy_cnt=1. Wb rd=7, data=0x12 -> busy drops combinationally that cycle, busy_cnt=0 after the edge.
- Issue rd=3 and wb rd=3 in the same cycle (3 previously pending) -> pending[3] stays 1, busy_cnt=1. Issue rd=3 again -> busy_cnt stays 1.
- Issue rd=1,2,4 on successive cycles (busy_cnt=3), then flush together with issue rd=9 and wb rd=2, data=0x55 -> busy_cnt=0, pending[9]=0, reg[2]=0x55.
- Wb rd=0, data=0xFFFFFFFF and issue rd=0, ZERO_REG=1 -> rs1_data(0)=0, rs1_busy=0, busy_cnt=0. Assert rst_n low mid-sequence with pending bits set -> everything 0 asynchronously.
